// File: rtl/router_pkg.sv
// Shared types and helpers for the mesh router input port:
// port numbering, flit layout, input-unit states and the XY routing function.
package router_pkg;

    localparam int NUM_PORTS  = 5;
    localparam int PORT_N     = 0;
    localparam int PORT_S     = 1;
    localparam int PORT_W     = 2;
    localparam int PORT_E     = 3;
    localparam int PORT_LOCAL = 4;

    localparam int FLIT_DATA_W = 32;
    localparam int HEAD_BIT    = FLIT_DATA_W + 1;
    localparam int TAIL_BIT    = FLIT_DATA_W;
    typedef logic [FLIT_DATA_W+1:0] flit_t;

    // Coordinates are zero-extended to this width before comparing, so one
    // function serves any X_W/Y_W that fits in a payload.
    localparam int COORD_W = 32;
    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        FORWARD = 2'd2
    } state_t;

    // Dimension-order routing: resolve X first, then Y, else deliver locally.
    function automatic logic [NUM_PORTS-1:0] xy_route(
        input coord_t dest_x,
        input coord_t dest_y,
        input coord_t pos_x,
        input coord_t pos_y
    );
        logic [NUM_PORTS-1:0] route;
        route = '0;
        if (dest_x > pos_x) begin
            route[PORT_E] = 1'b1;
        end else if (dest_x < pos_x) begin
            route[PORT_W] = 1'b1;
        end else if (dest_y > pos_y) begin
            route[PORT_N] = 1'b1;
        end else if (dest_y < pos_y) begin
            route[PORT_S] = 1'b1;
        end else begin
            route[PORT_LOCAL] = 1'b1;
        end
        return route;
    endfunction

endpackage

// File: rtl/router_input_fifo.sv
// Small circular flit buffer; the head entry is read combinationally so the
// routing logic sees a flit the cycle after it was written.
module router_input_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 34
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] top
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    // A pop never frees space for a simultaneous push when full.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);
    assign top   = mem[rd_ptr_reg];

endmodule

// File: rtl/router_input_unit.sv
// Input port of a 5-port wormhole mesh router: buffers flits, routes each
// head XY, requests an output and streams the packet through the crossbar.
module router_input_unit
    import router_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int X_W    = 3,
    parameter int Y_W    = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [X_W-1:0]       position_x,
    input  logic [Y_W-1:0]       position_y,
    input  logic                 in_valid,
    input  logic [DATA_W+1:0]    in_flit,
    output logic                 in_ready,
    output logic [NUM_PORTS-1:0] request,
    input  logic [NUM_PORTS-1:0] grant,
    input  logic [NUM_PORTS-1:0] grant_valid,
    input  logic [NUM_PORTS-1:0] out_ready,
    output logic [NUM_PORTS-1:0] forwarding_head,
    output logic [NUM_PORTS-1:0] forwarding_tail,
    output logic [NUM_PORTS-1:0] out_sel,
    output logic [DATA_W+1:0]    out_flit,
    output logic                 protocol_error
);

    localparam int FLIT_W = DATA_W + 2;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic [FLIT_W-1:0]    top_flit;
    logic                 top_head;
    logic                 top_tail;
    logic [X_W-1:0]       dest_x;
    logic [Y_W-1:0]       dest_y;
    logic                 req_fire;
    logic                 fwd_fire;
    state_t               state_reg;
    state_t               state_next;
    logic [NUM_PORTS-1:0] route_reg;
    logic [NUM_PORTS-1:0] route_next;

    assign in_ready = !fifo_full && !rst;
    assign push     = in_valid && in_ready;

    router_input_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FLIT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (in_flit),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .top   (top_flit)
    );

    assign top_head = top_flit[DATA_W+1];
    assign top_tail = top_flit[DATA_W];
    assign dest_x   = top_flit[X_W-1:0];
    assign dest_y   = top_flit[X_W+Y_W-1:X_W];
    assign out_flit = top_flit;

    // Head needs a valid grant; once locked the arbiter drops grant_valid,
    // so body flits only wait for downstream space.
    assign req_fire = |(grant & grant_valid & route_reg & out_ready);
    assign fwd_fire = !fifo_empty && |(route_reg & out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            route_reg <= '0;
        end else begin
            state_reg <= state_next;
            route_reg <= route_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        route_next = route_reg;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty && top_head) begin
                    route_next = xy_route(coord_t'(dest_x), coord_t'(dest_y),
                                          coord_t'(position_x), coord_t'(position_y));
                    state_next = REQUEST;
                end
            end
            REQUEST: begin
                if (req_fire) begin
                    state_next = top_tail ? IDLE : FORWARD;
                end
            end
            FORWARD: begin
                if (fwd_fire && top_tail) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pop             = 1'b0;
        protocol_error  = 1'b0;
        request         = '0;
        out_sel         = '0;
        forwarding_head = '0;
        forwarding_tail = '0;
        if (!rst) begin
            case (state_reg)
                IDLE: begin
                    if (!fifo_empty && !top_head) begin
                        pop            = 1'b1;
                        protocol_error = 1'b1;
                    end
                end
                REQUEST: begin
                    request = route_reg;
                    if (req_fire) begin
                        pop             = 1'b1;
                        out_sel         = route_reg;
                        forwarding_head = route_reg;
                        if (top_tail) begin
                            forwarding_tail = route_reg;
                        end
                    end
                end
                FORWARD: begin
                    request = route_reg;
                    if (fwd_fire) begin
                        pop     = 1'b1;
                        out_sel = route_reg;
                        if (top_tail) begin
                            forwarding_tail = route_reg;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_router_input_unit.sv
// Bench for router_input_unit: directed vector table, corner-case sequences
// and randomized packet traffic against a queue-based reference model.
module tb_router_input_unit;
    import router_pkg::*;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int X_W    = 3;
    localparam int Y_W    = 3;
    localparam int FW     = DATA_W + 2;

    localparam logic [4:0] PN = 5'b00001;
    localparam logic [4:0] PS = 5'b00010;
    localparam logic [4:0] PW = 5'b00100;
    localparam logic [4:0] PE = 5'b01000;
    localparam logic [4:0] PL = 5'b10000;
    localparam logic [4:0] P0 = 5'b00000;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [X_W-1:0] position_x = 3'd2;
    logic [Y_W-1:0] position_y = 3'd2;
    logic           in_valid = 1'b0;
    logic [FW-1:0]  in_flit = '0;
    logic           in_ready;
    logic [4:0]     request;
    logic [4:0]     grant = '0;
    logic [4:0]     grant_valid = '0;
    logic [4:0]     out_ready = '0;
    logic [4:0]     forwarding_head;
    logic [4:0]     forwarding_tail;
    logic [4:0]     out_sel;
    logic [FW-1:0]  out_flit;
    logic           protocol_error;

    always #5 clk = ~clk;

    router_input_unit #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .X_W    (X_W),
        .Y_W    (Y_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .position_x      (position_x),
        .position_y      (position_y),
        .in_valid        (in_valid),
        .in_flit         (in_flit),
        .in_ready        (in_ready),
        .request         (request),
        .grant           (grant),
        .grant_valid     (grant_valid),
        .out_ready       (out_ready),
        .forwarding_head (forwarding_head),
        .forwarding_tail (forwarding_tail),
        .out_sel         (out_sel),
        .out_flit        (out_flit),
        .protocol_error  (protocol_error)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: buffered flits, plus "holding a packet" / "head sent".
    logic [FW-1:0] mq[$];
    logic [FW-1:0] src[$];
    bit m_busy   = 1'b0;
    bit m_locked = 1'b0;
    int m_route  = 0;

    function automatic logic [FW-1:0] mk(input bit h, input bit t, input int dx, input int dy);
        logic [25:0] tg;
        tg = 26'($urandom);
        return {h, t, tg, 3'(dy), 3'(dx)};
    endfunction

    function automatic int route_of(input int dx, input int dy, input int px, input int py);
        if (dx > px) return 3;
        if (dx < px) return 2;
        if (dy > py) return 0;
        if (dy < py) return 1;
        return 4;
    endfunction

    task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit r, input bit v, input logic [FW-1:0] f,
                         input logic [4:0] g, input logic [4:0] gv, input logic [4:0] ordy,
                         output bit acc);
        logic [4:0]    e_req, e_sel, e_fh, e_ft;
        bit            e_perr, e_rdy, do_pop, have;
        logic [FW-1:0] topf;
        @(negedge clk);
        rst = r; in_valid = v; in_flit = f;
        grant = g; grant_valid = gv; out_ready = ordy;
        #1;
        e_req = '0; e_sel = '0; e_fh = '0; e_ft = '0; e_perr = 1'b0; do_pop = 1'b0;
        have  = mq.size() > 0;
        topf  = have ? mq[0] : '0;
        e_rdy = !r && (mq.size() < DEPTH);
        if (!r) begin
            if (!m_busy) begin
                if (have) begin
                    if (topf[FW-1]) begin
                        m_busy   = 1'b1;
                        m_locked = 1'b0;
                        m_route  = route_of(int'(topf[2:0]), int'(topf[5:3]),
                                            int'(position_x), int'(position_y));
                    end else begin
                        do_pop = 1'b1;
                        e_perr = 1'b1;
                    end
                end
            end else begin
                e_req = 5'(1 << m_route);
                if (!m_locked) begin
                    if (g[m_route] && gv[m_route] && ordy[m_route]) begin
                        do_pop = 1'b1; e_sel = e_req; e_fh = e_req;
                        if (topf[FW-2]) begin e_ft = e_req; m_busy = 1'b0; end
                        else m_locked = 1'b1;
                    end
                end else if (have && ordy[m_route]) begin
                    do_pop = 1'b1; e_sel = e_req;
                    if (topf[FW-2]) begin e_ft = e_req; m_busy = 1'b0; end
                end
            end
        end
        chk("in_ready", in_ready, e_rdy);
        chk("request", request, e_req);
        chk("out_sel", out_sel, e_sel);
        chk("fwd_head", forwarding_head, e_fh);
        chk("fwd_tail", forwarding_tail, e_ft);
        chk("protocol_error", protocol_error, e_perr);
        if (have && !r) chk("out_flit", out_flit, topf);
        if (do_pop) begin
            $display("pop flit=%h sel=%b head=%b tail=%b perr=%b", topf, e_sel, e_fh, e_ft, e_perr);
            void'(mq.pop_front());
        end
        acc = v && e_rdy;
        if (r) begin
            mq.delete();
            m_busy   = 1'b0;
            m_locked = 1'b0;
        end else if (acc) begin
            mq.push_back(f);
        end
    endtask

    task automatic drive_src(input bit allow, input logic [4:0] g, input logic [4:0] gv,
                             input logic [4:0] ordy);
        bit acc;
        bit v;
        v = allow && (src.size() > 0);
        cycle(1'b0, v, v ? src[0] : '0, g, gv, ordy, acc);
        if (acc) void'(src.pop_front());
    endtask

    task automatic run(input int n, input logic [4:0] g, input logic [4:0] gv, input logic [4:0] ordy);
        for (int i = 0; i < n; i++) drive_src(1'b1, g, gv, ordy);
    endtask

    typedef struct {
        bit         v;
        bit         h;
        bit         t;
        int         dx;
        int         dy;
        logic [4:0] gr;
        bit         e_rdy;
        logic [4:0] e_req;
        logic [4:0] e_sel;
        logic [4:0] e_fh;
        logic [4:0] e_ft;
        bit         e_perr;
    } vec_t;

    vec_t vt[13];

    initial begin
        bit acc;
        // 3-flit packet to (5,2) from (2,2), then single flit to (2,2), then stray body.
        vt[0]  = '{1, 1, 0, 5, 2, PE, 1, P0, P0, P0, P0, 0};
        vt[1]  = '{1, 0, 0, 5, 2, PE, 1, P0, P0, P0, P0, 0};
        vt[2]  = '{1, 0, 1, 5, 2, PE, 1, PE, PE, PE, P0, 0};
        vt[3]  = '{0, 0, 0, 0, 0, PE, 1, PE, PE, P0, P0, 0};
        vt[4]  = '{0, 0, 0, 0, 0, PE, 1, PE, PE, P0, PE, 0};
        vt[5]  = '{0, 0, 0, 0, 0, PE, 1, P0, P0, P0, P0, 0};
        vt[6]  = '{1, 1, 1, 2, 2, PL, 1, P0, P0, P0, P0, 0};
        vt[7]  = '{0, 0, 0, 0, 0, PL, 1, P0, P0, P0, P0, 0};
        vt[8]  = '{0, 0, 0, 0, 0, PL, 1, PL, PL, PL, PL, 0};
        vt[9]  = '{0, 0, 0, 0, 0, PL, 1, P0, P0, P0, P0, 0};
        vt[10] = '{1, 0, 0, 3, 3, PL, 1, P0, P0, P0, P0, 0};
        vt[11] = '{0, 0, 0, 0, 0, PL, 1, P0, P0, P0, P0, 1};
        vt[12] = '{0, 0, 0, 0, 0, PL, 1, P0, P0, P0, P0, 0};

        cycle(1'b1, 1'b0, '0, P0, P0, P0, acc);
        cycle(1'b1, 1'b0, '0, P0, P0, P0, acc);

        for (int i = 0; i < 13; i++) begin
            cycle(1'b0, vt[i].v, mk(vt[i].h, vt[i].t, vt[i].dx, vt[i].dy),
                  vt[i].gr, vt[i].gr, vt[i].gr, acc);
            chk($sformatf("v%0d_ready", i), in_ready, vt[i].e_rdy);
            chk($sformatf("v%0d_req", i), request, vt[i].e_req);
            chk($sformatf("v%0d_sel", i), out_sel, vt[i].e_sel);
            chk($sformatf("v%0d_fh", i), forwarding_head, vt[i].e_fh);
            chk($sformatf("v%0d_ft", i), forwarding_tail, vt[i].e_ft);
            chk($sformatf("v%0d_perr", i), protocol_error, vt[i].e_perr);
        end

        // Grant withheld toward S: request holds, FIFO fills, then drains.
        src = '{mk(1, 0, 2, 0), mk(0, 0, 2, 0), mk(0, 0, 2, 0), mk(0, 0, 2, 0), mk(0, 1, 2, 0)};
        run(6, PS, P0, PS);
        chk("stall_ready", in_ready, 1'b0);
        chk("stall_request", request, PS);
        run(10, PS, PS, PS);
        chk("stall_done_req", request, P0);

        // out_ready toward W toggles mid-packet.
        src = '{mk(1, 0, 0, 2), mk(0, 0, 0, 2), mk(0, 0, 0, 2), mk(0, 1, 0, 2)};
        run(4, PW, PW, P0);
        run(1, PW, PW, PW);
        run(2, PW, P0, P0);
        chk("toggle_hold_req", request, PW);
        run(5, PW, P0, PW);
        chk("toggle_done_req", request, P0);

        // Reset while forwarding with two body flits buffered.
        src = '{mk(1, 0, 5, 2), mk(0, 0, 5, 2), mk(0, 0, 5, 2), mk(0, 0, 5, 2)};
        run(5, PE, PE, P0);
        run(2, PE, P0, PE);
        cycle(1'b1, 1'b0, '0, PE, PE, PE, acc);
        src.delete();
        cycle(1'b0, 1'b0, '0, PE, PE, PE, acc);
        chk("post_rst_ready", in_ready, 1'b1);
        chk("post_rst_req", request, P0);
        src = '{mk(1, 1, 2, 2)};
        run(4, PL, PL, PL);

        // Randomized traffic from a random router position.
        position_x = 3'($urandom_range(0, 7));
        position_y = 3'($urandom_range(0, 7));
        for (int p = 0; p < 40; p++) begin
            int len, dx, dy;
            len = $urandom_range(1, 4);
            dx  = $urandom_range(0, 7);
            dy  = $urandom_range(0, 7);
            if ($urandom_range(0, 7) == 0) src.push_back(mk(0, $urandom_range(0, 1), dx, dy));
            for (int k = 0; k < len; k++) src.push_back(mk(k == 0, k == len - 1, dx, dy));
        end
        begin
            int budget;
            budget = 0;
            while ((src.size() > 0 || mq.size() > 0 || m_busy) && budget < 4000) begin
                drive_src($urandom_range(0, 3) != 0, 5'($urandom), 5'($urandom),
                          5'($urandom) | 5'($urandom));
                budget++;
            end
            if (budget >= 4000) begin
                total++;
                bad++;
                $display("FAIL drain_timeout: got %0d flits left expected 0", src.size() + mq.size());
            end
        end
        run(2, P0, P0, P0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
